// File: rtl/v2f_ram_arbiter.sv
// Two-requester arbiter/sequencer in front of v2f_programmable_ram: shares its read and
// write ports between instruction fetch and data, gates traffic during boot, flags bad addresses.
module v2f_ram_arbiter #(
  parameter int unsigned ABITS       = 2,
  parameter int unsigned SIZE        = 4,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             ARST,

  input  logic             I_REQ,
  input  logic [ABITS-1:0] I_ADDR,
  output logic             I_GNT,
  output logic             I_RVALID,
  output logic [31:0]      I_RDATA,
  output logic             I_ERR,

  input  logic             D_REQ,
  input  logic             D_WE,
  input  logic [ABITS-1:0] D_ADDR,
  input  logic [31:0]      D_WDATA,
  input  logic [3:0]       D_BE,
  output logic             D_GNT,
  output logic             D_RVALID,
  output logic [31:0]      D_RDATA,
  output logic             D_ERR,

  output logic             MEM_ARST,
  output logic             MEM_RD_EN,
  output logic [ABITS-1:0] MEM_RD_ADDR,
  input  logic [31:0]      MEM_RD_DATA,
  output logic             MEM_WR_EN,
  output logic [ABITS-1:0] MEM_WR_ADDR,
  output logic [31:0]      MEM_WR_DATA,
  output logic [3:0]       MEM_BYTE_SELECT
);

  typedef enum logic [1:0] {
    RESET = 2'd0,
    BOOT  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [7:0] BOOT_LOAD = 8'(BOOT_CYCLES);

  state_t     state;
  logic [7:0] boot_cnt;
  logic       last;
  logic       owner;
  logic       err;
  logic       rsp_pending;

  logic       i_oor;
  logic       d_oor;

  assign i_oor = 32'(I_ADDR) >= SIZE;
  assign d_oor = 32'(D_ADDR) >= SIZE;

  // last = 1 means data won the previous grant, so fetch wins the next conflict.
  always_comb begin
    I_GNT = 1'b0;
    D_GNT = 1'b0;
    if (state == RUN) begin
      if (I_REQ && D_REQ) begin
        I_GNT = last;
        D_GNT = !last;
      end else begin
        I_GNT = I_REQ;
        D_GNT = D_REQ;
      end
    end
  end

  always_comb begin
    MEM_RD_EN       = 1'b0;
    MEM_RD_ADDR     = '0;
    MEM_WR_EN       = 1'b0;
    MEM_WR_ADDR     = '0;
    MEM_WR_DATA     = '0;
    MEM_BYTE_SELECT = '0;
    if (I_GNT && !i_oor) begin
      MEM_RD_EN   = 1'b1;
      MEM_RD_ADDR = I_ADDR;
    end else if (D_GNT && !d_oor) begin
      if (D_WE) begin
        MEM_WR_EN       = 1'b1;
        MEM_WR_ADDR     = D_ADDR;
        MEM_WR_DATA     = D_WDATA;
        MEM_BYTE_SELECT = D_BE;
      end else begin
        MEM_RD_EN   = 1'b1;
        MEM_RD_ADDR = D_ADDR;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (ARST) begin
      state       <= RESET;
      boot_cnt    <= BOOT_LOAD;
      last        <= 1'b1;
      owner       <= 1'b0;
      err         <= 1'b0;
      rsp_pending <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          state    <= BOOT;
          boot_cnt <= BOOT_LOAD;
        end
        BOOT: begin
          boot_cnt <= boot_cnt - 8'd1;
          if (boot_cnt <= 8'd1) begin
            state <= RUN;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= RESET;
        end
      endcase

      // Out-of-range grants still produce a one-cycle response, just with err set.
      rsp_pending <= I_GNT || (D_GNT && !D_WE);
      err         <= (I_GNT && i_oor) || (D_GNT && d_oor);
      if (I_GNT || D_GNT) begin
        owner <= D_GNT;
        last  <= D_GNT;
      end
    end
  end

  assign I_RVALID = rsp_pending && !owner;
  assign D_RVALID = rsp_pending && owner;
  assign I_ERR    = err && !owner;
  assign D_ERR    = err && owner;
  assign I_RDATA  = (I_RVALID && !err) ? MEM_RD_DATA : 32'd0;
  assign D_RDATA  = (D_RVALID && !err) ? MEM_RD_DATA : 32'd0;
  assign MEM_ARST = ARST;

endmodule
